// File: rtl/core_if_pf_if.sv
// Pipelined wishbone fetch bus between the prefetcher (master) and memory (slave).
// Define CORE_IF_PF_ERR_EN to add the bus_err response line.
interface core_if_pf_if #(
  parameter int AW = 32
);
  logic [AW-1:0] bus_adr;
  logic          bus_cyc;
  logic          bus_stb;
  logic          bus_we;
  logic [3:0]    bus_sel;
  logic [31:0]   bus_dat_i;
  logic          bus_ack;
  logic          bus_stall;
`ifdef CORE_IF_PF_ERR_EN
  logic          bus_err;
`endif

  modport master (
    output bus_adr, bus_cyc, bus_stb, bus_we, bus_sel,
    input  bus_dat_i, bus_ack, bus_stall
`ifdef CORE_IF_PF_ERR_EN
    , input bus_err
`endif
  );

  modport slave (
    input  bus_adr, bus_cyc, bus_stb, bus_we, bus_sel,
    output bus_dat_i, bus_ack, bus_stall
`ifdef CORE_IF_PF_ERR_EN
    , output bus_err
`endif
  );
endinterface

// File: rtl/core_if_pf.sv
// Instruction prefetcher: issues pipelined wishbone reads into a DEPTH-entry FIFO.
// Optional fault reporting (bus_err / if_fault) is enabled by defining CORE_IF_PF_ERR_EN.
module core_if_pf #(
  parameter int          AW       = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  core_if_pf_if.master    bus,
  input  logic            if_halt,
  input  logic            set_pc,
  input  logic [AW-1:0]   new_pc,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [AW-1:0]   if_pc,
  output logic [31:0]     if_instr
`ifdef CORE_IF_PF_ERR_EN
  , output logic          if_fault
`endif
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = PW + 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PC_INC   = AW'(4);
  localparam logic [AW-1:0] RST_PC   = RESET_PC[AW-1:0];
  localparam logic [AW-1:0] ALIGN_MK = {{(AW - 2){1'b1}}, 2'b00};

  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] rpc_q, rpc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;

  logic [AW-1:0] pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic [CW:0]   credit_sum;
  logic          err_in;
  logic          blocked;
  logic          stb;
  logic          issue;
  logic          resp;
  logic          dropping;
  logic          push;
  logic          pop;

`ifdef CORE_IF_PF_ERR_EN
  logic fault_q, fault_d;
  assign err_in   = bus.bus_err;
  assign blocked  = fault_q;
  assign if_fault = fault_q;
`else
  assign err_in   = 1'b0;
  assign blocked  = 1'b0;
`endif

  // Credits count both buffered entries and in-flight requests, so the FIFO can never overflow.
  assign credit_sum = {1'b0, cnt_q} + {1'b0, out_q};
  assign stb        = !rst && !if_halt && !set_pc && !blocked && (credit_sum < DEPTH_C);
  assign issue      = stb && !bus.bus_stall;
  assign resp       = (bus.bus_ack || err_in) && (out_q != '0);
  assign dropping   = resp && (drop_q != '0);
  assign push       = resp && !dropping && bus.bus_ack && !err_in && !set_pc && !rst;
  assign pop        = (cnt_q != '0) && if_ready;

  always_comb begin
    fpc_d  = issue ? fpc_q + PC_INC : fpc_q;
    rpc_d  = push ? rpc_q + PC_INC : rpc_q;
    out_d  = out_q + CW'(issue) - CW'(resp);
    drop_d = dropping ? drop_q - CW'(1) : drop_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    wr_d   = push ? wr_q + PW'(1) : wr_q;
    rd_d   = pop ? rd_q + PW'(1) : rd_q;
`ifdef CORE_IF_PF_ERR_EN
    fault_d = fault_q | (err_in && resp && !dropping);
`endif
    // Redirect: everything still in flight becomes a response to discard.
    if (set_pc) begin
      fpc_d  = new_pc & ALIGN_MK;
      rpc_d  = new_pc & ALIGN_MK;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      drop_d = out_q - CW'(resp);
`ifdef CORE_IF_PF_ERR_EN
      fault_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q   <= RST_PC;
      rpc_q   <= RST_PC;
      cnt_q   <= '0;
      out_q   <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
`ifdef CORE_IF_PF_ERR_EN
      fault_q <= 1'b0;
`endif
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
`ifdef CORE_IF_PF_ERR_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Entry storage carries no reset; empty slots are masked at the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= rpc_q;
      ins_mem[wr_q] <= bus.bus_dat_i;
    end
  end

  assign bus.bus_adr = fpc_q;
  assign bus.bus_stb = stb;
  assign bus.bus_cyc = stb || (!rst && (out_q != '0));
  assign bus.bus_we  = 1'b0;
  assign bus.bus_sel = 4'hF;

  assign if_valid = !rst && (cnt_q != '0);
  assign if_pc    = if_valid ? pc_mem[rd_q] : '0;
  assign if_instr = if_valid ? ins_mem[rd_q] : '0;

endmodule

// File: doc/core_if_pf.md
CORE_IF_PF -- requirements
Module: core_if_pf

Interface
REQ-001 SHALL have parameter AW, default 32: fetch address width in bits; legal range 8..32.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch FIFO entries and the outstanding-request limit; power of 2, minimum 2.
REQ-003 SHALL have parameter RESET_PC, default 0: fetch address after reset; must be word aligned.
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 SHALL have port: clk  in  1  clock; all logic on the rising edge.
REQ-006 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have bus master ports (pipelined wishbone):
- bus_adr  out  AW  fetch address.
- bus_cyc  out  1  cycle active.
- bus_stb  out  1  request strobe.
- bus_we  out  1  write enable; constant 0.
- bus_sel  out  4  byte select; constant 4'hF.
- bus_dat_i  in  32  read data.
- bus_ack  in  1  response.
- bus_stall  in  1  slave cannot accept a request.
REQ-008 SHALL have core-side ports:
- if_halt  in  1  suppress new requests.
- set_pc  in  1  redirect.
- new_pc  in  AW  redirect target.
- if_ready  in  1  consumer accepts the head entry.
- if_valid  out  1  head entry present.
- if_pc  out  AW  address of the head entry.
- if_instr  out  32  head instruction.

Function
REQ-009 SHALL maintain fpc (next issue address), rpc (address of the next non-dropped response), cnt (FIFO occupancy), out (issued but unacknowledged requests, including dropped ones) and drop (responses still to be discarded).
REQ-010 SHALL drive bus_stb=1 exactly when !rst && !if_halt && !set_pc && (cnt+out)<DEPTH; bus_adr=fpc.
REQ-011 SHALL drive bus_cyc = bus_stb || out!=0.
REQ-012 SHALL treat a request as issued when bus_stb && !bus_stall; on issue, fpc+=4 (modulo 2^AW) and out+=1.
REQ-013 SHALL decrement out on bus_ack when out!=0.
REQ-014 SHALL, on bus_ack with drop!=0, decrement drop and discard the data.
REQ-015 SHALL, on bus_ack with drop==0, push {rpc, bus_dat_i} into the FIFO and then set rpc+=4.
REQ-016 SHALL ignore bus_ack when out==0 (protocol error): no state change.
REQ-017 SHALL have 1-cycle response latency: an ack in cycle N makes the entry visible on if_valid/if_pc/if_instr in cycle N+1.
REQ-018 SHALL drive if_valid = cnt!=0, and SHALL pop the head when if_valid && if_ready.
REQ-019 SHALL allow push and pop in the same cycle, including at full; the credit rule of REQ-010 guarantees the FIFO never overflows.
REQ-020 SHALL, on set_pc, in the same cycle:
- flush the FIFO (cnt=0);
- set fpc=rpc={new_pc[AW-1:2],2'b00};
- set drop = out minus any ack arriving this cycle;
- issue no request.
REQ-021 SHALL resume issuing the cycle after set_pc; new requests may overlap draining of dropped responses.
REQ-022 SHALL give set_pc priority over a pop and over if_halt; a pop in a set_pc cycle has no further effect.
REQ-023 SHALL, under if_halt, issue no new requests but still accept acks and pops.
REQ-024 SHALL wrap fpc and rpc from 2^AW-4 to 0 without error.

Reset
REQ-025 SHALL, on rst, set fpc=rpc=RESET_PC and cnt=out=drop=0.
REQ-026 SHALL hold these outputs during and after reset: bus_stb=0, bus_cyc=0, if_valid=0, if_pc=0, if_instr=0.
REQ-027 SHALL, on rst mid-transaction, abandon outstanding requests immediately; their acks arrive with out==0 and are ignored per REQ-016.

Configuration
REQ-028 SHALL, with CORE_IF_PF_ERR_EN defined, add ports bus_err (in 1) and if_fault (out 1, reset 0).
REQ-029 SHALL, with CORE_IF_PF_ERR_EN defined, treat bus_err like an ack for out/drop accounting, without pushing data.
REQ-030 SHALL, with CORE_IF_PF_ERR_EN defined, on a non-dropped bus_err: set if_fault sticky, and block issue until set_pc, which also clears if_fault.
REQ-031 SHALL, with CORE_IF_PF_ERR_EN undefined, have no bus_err or if_fault ports and no fault logic.

Verification
REQ-032 SHALL cover: reset, RESET_PC=0x100, stall=0, 1-cycle ack, if_ready=1 -> bus_adr 0x100,0x104,0x108...; if_pc follows one cycle after each ack with matching data.
REQ-033 SHALL cover: DEPTH=4, if_ready=0, immediate acks -> exactly 4 requests issued, then bus_stb=0 with cnt=4; one pop -> exactly one new request.
REQ-034 SHALL cover: 3 requests outstanding, set_pc with new_pc=0x2002 -> FIFO empty next cycle, next bus_adr=0x2000, 3 stale acks discarded, first entry if_pc=0x2000.
REQ-035 SHALL cover: AW=16, fpc=0xFFFC -> next issue address 0x0000; if_pc wraps identically.
REQ-036 SHALL cover: if_halt asserted with 2 outstanding -> bus_stb=0, both acks still enter the FIFO, bus_cyc drops after the second ack.
REQ-037 SHALL cover, with CORE_IF_PF_ERR_EN: bus_err on the request for 0x40 -> if_fault=1, no further bus_stb; set_pc to 0x80 -> if_fault=0, issue resumes at 0x80.
